usb_tx_arbiter: RTL and testbench
=================================

Name: usb_tx_arbiter

Overview:
- Shares the single serial transmit path (NRZI encoder, then line driver) between three packet serializers: handshake, token and data.
- Grants one requester at a time and forwards its bits with a packet-type code on bstr_out_ready, matching the NRZI encoder's input format.
- Sequences each packet as SEND, then EOP, then inter-packet gap.
- Enforces a maximum packet length and flags protocol violations.

Parameters:
- MAX_BITS, 92: maximum bits per packet including SYNC; a longer packet is forcibly terminated.
- EOP_CYCLES, 2: cycles of eop assertion after the last bit.
- GAP_CYCLES, 2: idle cycles after EOP before the next grant.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- hs_req / hs_bit / hs_last  in  1 each  handshake requester: request, serial bit, final-bit marker
- hs_gnt  out  1  handshake grant
- tok_req / tok_bit / tok_last  in  1 each  token requester
- tok_gnt  out  1  token grant
- dat_req / dat_bit / dat_last  in  1 each  data requester
- dat_gnt  out  1  data grant
- bstr_out  out  1  forwarded bit to the NRZI encoder
- bstr_out_ready  out  2  packet type of bstr_out: 00 none, 01 token, 10 data, 11 handshake
- eop  out  1  line driver forces SE0 while high
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on abnormal termination

Behaviour:
- Reset values (asynchronous): state IDLE, all gnt 0, bstr_out 1, bstr_out_ready 00, eop 0, busy 0, err 0, bit counter 0.
- Reset asserted mid-packet aborts the packet immediately; no EOP is generated.
- States: IDLE, SEND, EOP, GAP.
- IDLE:
  - If any req is high, pick the owner by fixed priority: hs > tok > dat.
  - Register the owner and go to SEND; the owner's gnt rises the next cycle.
  - Requests arriving in the same cycle resolve by priority; losers wait and keep req high.
- SEND:
  - In every cycle the owner's gnt is high, the owner's bit and last are sampled.
  - Next cycle: bstr_out = sampled bit, bstr_out_ready = owner code. Latency from gnt-cycle sample to output is 1 cycle.
  - Bit counter increments per sampled bit (7 bits wide, saturating).
  - Owner must keep req high and drive a valid bit every granted cycle.
- Normal end: last sampled high.
  - gnt drops the next cycle (same cycle the final bit appears on bstr_out).
  - Then EOP.
- Abnormal end, either condition:
  - (a) owner req low while granted: that cycle's bit is discarded.
  - (b) counter reaches MAX_BITS without last: the MAX_BITS-th bit is forwarded.
  - Both cause: err pulses for 1 cycle, gnt drops, state goes to EOP.
  - If last and the overflow coincide on bit MAX_BITS, treat as a normal end with no err.
- EOP:
  - eop = 1, bstr_out_ready = 00, bstr_out = 1 for EOP_CYCLES cycles, then GAP.
- GAP:
  - All outputs idle (bstr_out 1, ready 00, eop 0) for GAP_CYCLES cycles, then IDLE.
  - Requests raised during EOP or GAP are held pending and arbitrated in IDLE. A higher-priority request raised there wins.
- No preemption: a higher-priority req during SEND waits for the packet to finish.
- Counter clears on entry to SEND.
- Inputs of non-owners are ignored.
- At most one gnt is high at any time; gnt is never high outside SEND.
- busy is high from the cycle after the grant decision through the last GAP cycle.
- Minimum packet spacing: last data bit, then EOP_CYCLES + GAP_CYCLES + 1 (IDLE) + 1 (grant) cycles, then the next first bit.

Decomposition:
- Shared package usb_tx_pkg holds:
  - packet-type enum (PT_NONE 00, PT_TOK 01, PT_DATA 10, PT_HS 11);
  - size constants TOK_BITS 28, HS_BITS 12, DATA_BITS 92;
  - the state enum typedef.
- Sub-module usb_tx_prio_enc: 3-input fixed-priority encoder returning a one-hot owner and packet-type code.
- FSM, counter and muxes stay in usb_tx_arbiter.

Test Plan:
- Token only: tok_req with 28 bits, tok_last on bit 28.
  - tok_gnt rises 1 cycle after req and stays high 28 cycles.
  - bstr_out_ready = 01 for 28 cycles, lagging gnt by 1.
  - eop high 2 cycles, then 2 idle cycles, busy low after; err stays 0.
- Simultaneous hs_req, tok_req, dat_req in the same IDLE cycle.
  - Order is hs (12 bits, ready 11), then tok (01), then dat (10).
  - Each packet is separated by 2 eop + 2 gap + 1 idle cycles.
  - At most one gnt is high in any cycle.
- hs_req raised mid data packet (bit 40 of 92).
  - Data runs to completion uninterrupted; hs_gnt rises only after GAP plus IDLE.
- Data requester never asserts last.
  - After 92 bits, err pulses 1 cycle, dat_gnt drops, eop high 2 cycles.
  - Next case: last on bit 92 gives a normal end with err 0.
- tok_req dropped after bit 10.
  - err pulses; exactly 10 bits appear with ready 01; eop follows.
- rst_b asserted during SEND bit 5.
  - All outputs return to reset values asynchronously: bstr_out 1, ready 00, gnts 0, eop 0.
  - After release, a pending req is granted normally.

Source files
------------

// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_pkg
//  Description : Shared types and constants for the USB transmit arbiter:
//                packet-type codes, nominal packet sizes, FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    // Packet-type code forwarded alongside each bit to the NRZI encoder
    typedef enum logic [1:0] {
        PT_NONE = 2'b00,
        PT_TOK  = 2'b01,
        PT_DATA = 2'b10,
        PT_HS   = 2'b11
    } pkt_type_e;

    // Nominal packet lengths in bits, SYNC included
    localparam int TOK_BITS  = 28;
    localparam int HS_BITS   = 12;
    localparam int DATA_BITS = 92;

    // Bit positions of each requester in the one-hot owner vector
    localparam int OWN_HS  = 0;
    localparam int OWN_TOK = 1;
    localparam int OWN_DAT = 2;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_EOP  = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_e;

endpackage : usb_tx_pkg
`default_nettype wire

// File: rtl/usb_tx_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_prio_enc
//  Description : Fixed-priority (hs > tok > dat) encoder producing a one-hot
//                owner and the matching packet-type code.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_prio_enc
    import usb_tx_pkg::*;
(
    input  logic       hs_i,
    input  logic       tok_i,
    input  logic       dat_i,
    output logic [2:0] onehot_o,
    output pkt_type_e  pt_o,
    output logic       valid_o
);

    // Highest-priority active request wins
    always_comb begin
        onehot_o = 3'b000;
        pt_o     = PT_NONE;
        if (hs_i) begin
            onehot_o[OWN_HS] = 1'b1;
            pt_o             = PT_HS;
        end else if (tok_i) begin
            onehot_o[OWN_TOK] = 1'b1;
            pt_o              = PT_TOK;
        end else if (dat_i) begin
            onehot_o[OWN_DAT] = 1'b1;
            pt_o              = PT_DATA;
        end
    end

    assign valid_o = hs_i | tok_i | dat_i;

endmodule : usb_tx_prio_enc
`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_arbiter
//  Description : Shares the NRZI/line-driver transmit path between the
//                handshake, token and data serializers. Sequences each packet
//                as SEND -> EOP -> GAP, limits packet length, flags aborts.
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int MAX_BITS   = 92,
    parameter int EOP_CYCLES = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       hs_req,
    input  logic       hs_bit,
    input  logic       hs_last,
    output logic       hs_gnt,
    input  logic       tok_req,
    input  logic       tok_bit,
    input  logic       tok_last,
    output logic       tok_gnt,
    input  logic       dat_req,
    input  logic       dat_bit,
    input  logic       dat_last,
    output logic       dat_gnt,
    output logic       bstr_out,
    output logic [1:0] bstr_out_ready,
    output logic       eop,
    output logic       busy,
    output logic       err
);

    tx_state_e  state_q, state_d;
    logic [2:0] owner_q, owner_d;
    pkt_type_e  pt_q, pt_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] tmr_q, tmr_d;
    logic       bstr_q, bstr_d;
    pkt_type_e  ready_q, ready_d;
    logic       err_q, err_d;

    logic [2:0] enc_onehot;
    pkt_type_e  enc_pt;
    logic       enc_valid;
    logic       own_req, own_bit, own_last;

    usb_tx_prio_enc u_prio_enc (
        .hs_i     (hs_req),
        .tok_i    (tok_req),
        .dat_i    (dat_req),
        .onehot_o (enc_onehot),
        .pt_o     (enc_pt),
        .valid_o  (enc_valid)
    );

    // Only the registered owner's inputs are observed; others are ignored
    assign own_req  = |(owner_q & {dat_req,  tok_req,  hs_req});
    assign own_bit  = |(owner_q & {dat_bit,  tok_bit,  hs_bit});
    assign own_last = |(owner_q & {dat_last, tok_last, hs_last});

    // State, counters and registered output stage
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            owner_q <= 3'b000;
            pt_q    <= PT_NONE;
            cnt_q   <= 7'd0;
            tmr_q   <= 8'd0;
            bstr_q  <= 1'b1;
            ready_q <= PT_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            pt_q    <= pt_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            bstr_q  <= bstr_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Next-state: arbitration, bit forwarding, termination and EOP/GAP timing.
    // The first EOP-state cycle (tmr 0) carries the final forwarded bit, so
    // eop itself is only driven for tmr 1..EOP_CYCLES.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        pt_d    = pt_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        bstr_d  = 1'b1;
        ready_d = PT_NONE;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_valid) begin
                    owner_d = enc_onehot;
                    pt_d    = enc_pt;
                    cnt_d   = 7'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!own_req) begin
                    // Requester abandoned the packet: discard this bit
                    err_d   = 1'b1;
                    tmr_d   = 8'd0;
                    state_d = ST_EOP;
                end else begin
                    bstr_d  = own_bit;
                    ready_d = pt_q;
                    cnt_d   = (cnt_q == 7'h7f) ? cnt_q : cnt_q + 7'd1;
                    if (own_last) begin
                        tmr_d   = 8'd0;
                        state_d = ST_EOP;
                    end else if (cnt_q == 7'(MAX_BITS - 1)) begin
                        // Overlong packet: forward this bit, then force EOP
                        err_d   = 1'b1;
                        tmr_d   = 8'd0;
                        state_d = ST_EOP;
                    end
                end
            end
            ST_EOP: begin
                if (tmr_q == 8'(EOP_CYCLES)) begin
                    tmr_d   = 8'd0;
                    state_d = ST_GAP;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (tmr_q == 8'(GAP_CYCLES - 1)) begin
                    tmr_d   = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign hs_gnt         = (state_q == ST_SEND) & owner_q[OWN_HS];
    assign tok_gnt        = (state_q == ST_SEND) & owner_q[OWN_TOK];
    assign dat_gnt        = (state_q == ST_SEND) & owner_q[OWN_DAT];
    assign bstr_out       = bstr_q;
    assign bstr_out_ready = ready_q;
    assign eop            = (state_q == ST_EOP) && (tmr_q != 8'd0);
    assign busy           = (state_q != ST_IDLE);
    assign err            = err_q;

endmodule : usb_tx_arbiter
`default_nettype wire

// File: tb/tb_usb_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_tx_arbiter
//  Description : Directed self-checking bench for usb_tx_arbiter. Behavioural
//                requesters drive patterned bits while granted; a per-cycle
//                monitor gathers statistics compared to hand-derived values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       hs_req = 0, hs_bit = 0, hs_last = 0;
    logic       tok_req = 0, tok_bit = 0, tok_last = 0;
    logic       dat_req = 0, dat_bit = 0, dat_last = 0;
    logic       hs_gnt, tok_gnt, dat_gnt;
    logic       bstr_out;
    logic [1:0] bstr_out_ready;
    logic       eop, busy, err;

    usb_tx_arbiter #(.MAX_BITS(92), .EOP_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst_b(rst_b),
        .hs_req(hs_req), .hs_bit(hs_bit), .hs_last(hs_last), .hs_gnt(hs_gnt),
        .tok_req(tok_req), .tok_bit(tok_bit), .tok_last(tok_last), .tok_gnt(tok_gnt),
        .dat_req(dat_req), .dat_bit(dat_bit), .dat_last(dat_last), .dat_gnt(dat_gnt),
        .bstr_out(bstr_out), .bstr_out_ready(bstr_out_ready),
        .eop(eop), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Requester model: index 0 = hs, 1 = tok, 2 = dat
    bit req_en[3];
    bit nolast[3];
    int idx[3];
    int len[3];
    int drop_at[3];
    logic [2:0] req_v, bit_v, last_v;

    // Monitor statistics
    int cyc;
    int gnt_cnt[3], first_gnt[3], ready_cnt[4], oidx[3];
    int eop_cnt, eop_first, err_cnt, err_first, last_busy, multi_gnt, bit_bad;
    logic [1:0] prev_ready;
    logic [1:0] order[$];

    function automatic logic pat(input int r, input int i);
        return ((i * 5 + r) % 7) < 3;
    endfunction

    function automatic int code2idx(input logic [1:0] c);
        return (c == 2'b11) ? 0 : (c == 2'b01) ? 1 : 2;
    endfunction

    task automatic set_req(input int r, input int l, input int drop, input bit nl);
        req_en[r]  = 1'b1;
        idx[r]     = 0;
        len[r]     = l;
        drop_at[r] = drop;
        nolast[r]  = nl;
    endtask

    task automatic clear_stats();
        cyc = 0;
        for (int r = 0; r < 3; r++) begin
            gnt_cnt[r] = 0; first_gnt[r] = -1; oidx[r] = 0;
        end
        for (int c = 0; c < 4; c++) ready_cnt[c] = 0;
        eop_cnt = 0; eop_first = -1; err_cnt = 0; err_first = -1;
        last_busy = -1; multi_gnt = 0; bit_bad = 0;
        prev_ready = 2'b00;
        order.delete();
    endtask

    task automatic drive();
        for (int r = 0; r < 3; r++) begin
            req_v[r]  = req_en[r] && (idx[r] < drop_at[r]);
            bit_v[r]  = pat(r, idx[r]);
            last_v[r] = !nolast[r] && (idx[r] == len[r] - 1);
        end
        hs_req  = req_v[0]; hs_bit  = bit_v[0]; hs_last  = last_v[0];
        tok_req = req_v[1]; tok_bit = bit_v[1]; tok_last = last_v[1];
        dat_req = req_v[2]; dat_bit = bit_v[2]; dat_last = last_v[2];
    endtask

    // One clock: drive inputs, advance requesters on the edge, sample #1 later
    task automatic step();
        logic [2:0] g_pre;
        logic [2:0] g;
        int r;
        drive();
        g_pre = {dat_gnt, tok_gnt, hs_gnt};
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (g_pre[k] && req_v[k]) begin
                if (last_v[k]) req_en[k] = 1'b0;
                idx[k]++;
            end
        end
        #1;
        cyc++;
        g = {dat_gnt, tok_gnt, hs_gnt};
        for (int k = 0; k < 3; k++) begin
            if (g[k]) begin
                gnt_cnt[k]++;
                if (first_gnt[k] < 0) first_gnt[k] = cyc;
            end
        end
        if ($countones(g) > 1) multi_gnt++;
        if (bstr_out_ready != 2'b00) begin
            ready_cnt[bstr_out_ready]++;
            r = code2idx(bstr_out_ready);
            if (prev_ready == 2'b00) order.push_back(bstr_out_ready);
            if (bstr_out !== pat(r, oidx[r])) bit_bad++;
            oidx[r]++;
        end
        prev_ready = bstr_out_ready;
        if (eop) begin
            eop_cnt++;
            if (eop_first < 0) eop_first = cyc;
        end
        if (err) begin
            err_cnt++;
            if (err_first < 0) err_first = cyc;
        end
        if (busy) last_busy = cyc;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        for (int r = 0; r < 3; r++) begin
            req_en[r] = 0; nolast[r] = 0; idx[r] = 0; len[r] = 1; drop_at[r] = 1000;
        end
        clear_stats();

        // Power-on reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bstr",  bstr_out, 1);
        check_eq("rst_ready", bstr_out_ready, 0);
        check_eq("rst_gnts",  {dat_gnt, tok_gnt, hs_gnt}, 0);
        check_eq("rst_eop",   eop, 0);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_err",   err, 0);
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Token-only packet, 28 bits
        clear_stats();
        set_req(1, 28, 1000, 0);
        run(40);
        check_eq("tok_first_gnt",  first_gnt[1], 1);
        check_eq("tok_gnt_cnt",    gnt_cnt[1], 28);
        check_eq("tok_ready_cnt",  ready_cnt[1], 28);
        check_eq("tok_bits",       bit_bad, 0);
        check_eq("tok_eop_first",  eop_first, 30);
        check_eq("tok_eop_cnt",    eop_cnt, 2);
        check_eq("tok_err",        err_cnt, 0);
        check_eq("tok_last_busy",  last_busy, 33);

        // Simultaneous requests: hs, then tok, then dat
        clear_stats();
        set_req(0, 12, 1000, 0);
        set_req(1, 28, 1000, 0);
        set_req(2, 92, 1000, 0);
        run(155);
        check_eq("sim_order_n",  order.size(), 3);
        if (order.size() == 3) begin
            check_eq("sim_order0", order[0], 3);
            check_eq("sim_order1", order[1], 1);
            check_eq("sim_order2", order[2], 2);
        end
        check_eq("sim_hs_gnt",   first_gnt[0], 1);
        check_eq("sim_tok_gnt",  first_gnt[1], 19);
        check_eq("sim_dat_gnt",  first_gnt[2], 53);
        check_eq("sim_hs_cnt",   ready_cnt[3], 12);
        check_eq("sim_tok_cnt",  ready_cnt[1], 28);
        check_eq("sim_dat_cnt",  ready_cnt[2], 92);
        check_eq("sim_multi",    multi_gnt, 0);
        check_eq("sim_bits",     bit_bad, 0);
        check_eq("sim_eop_cnt",  eop_cnt, 6);
        check_eq("sim_err",      err_cnt, 0);
        check_eq("sim_busy",     last_busy, 149);

        // hs raised at data bit 40: no preemption
        clear_stats();
        set_req(2, 92, 1000, 0);
        begin
            bit raised = 0;
            for (int k = 0; k < 120; k++) begin
                step();
                if (!raised && idx[2] == 40) begin
                    set_req(0, 12, 1000, 0);
                    raised = 1;
                end
            end
        end
        check_eq("mid_dat_gnt",   gnt_cnt[2], 92);
        check_eq("mid_dat_ready", ready_cnt[2], 92);
        check_eq("mid_hs_first",  first_gnt[0], 99);
        check_eq("mid_hs_ready",  ready_cnt[3], 12);
        check_eq("mid_multi",     multi_gnt, 0);
        check_eq("mid_err",       err_cnt, 0);

        // Data never asserts last: forced termination at 92 bits
        clear_stats();
        set_req(2, 200, 92, 1);
        run(100);
        check_eq("ovf_gnt_cnt",   gnt_cnt[2], 92);
        check_eq("ovf_ready_cnt", ready_cnt[2], 92);
        check_eq("ovf_bits",      bit_bad, 0);
        check_eq("ovf_err_cnt",   err_cnt, 1);
        check_eq("ovf_err_cyc",   err_first, 93);
        check_eq("ovf_eop_first", eop_first, 94);
        check_eq("ovf_eop_cnt",   eop_cnt, 2);

        // Last on bit 92: normal end
        clear_stats();
        set_req(2, 92, 1000, 0);
        run(100);
        check_eq("b92_ready_cnt", ready_cnt[2], 92);
        check_eq("b92_err_cnt",   err_cnt, 0);
        check_eq("b92_eop_first", eop_first, 94);

        // Token drops req after 10 bits
        clear_stats();
        set_req(1, 28, 10, 0);
        run(20);
        check_eq("drop_ready_cnt", ready_cnt[1], 10);
        check_eq("drop_bits",      bit_bad, 0);
        check_eq("drop_err_cnt",   err_cnt, 1);
        check_eq("drop_err_cyc",   err_first, 12);
        check_eq("drop_eop_first", eop_first, 13);
        check_eq("drop_eop_cnt",   eop_cnt, 2);
        check_eq("drop_last_busy", last_busy, 16);

        // Asynchronous reset during SEND bit 5
        clear_stats();
        set_req(1, 28, 1000, 0);
        run(6);
        check_eq("arst_pre_ready", bstr_out_ready, 1);
        #2;
        rst_b = 1'b0;
        #1;
        check_eq("arst_bstr",  bstr_out, 1);
        check_eq("arst_ready", bstr_out_ready, 0);
        check_eq("arst_gnts",  {dat_gnt, tok_gnt, hs_gnt}, 0);
        check_eq("arst_eop",   eop, 0);
        check_eq("arst_busy",  busy, 0);
        #1;
        set_req(1, 28, 1000, 0);
        clear_stats();
        rst_b = 1'b1;
        run(40);
        check_eq("arst_eop_before", eop_first, 30);
        check_eq("arst_first_gnt",  first_gnt[1], 1);
        check_eq("arst_ready_cnt",  ready_cnt[1], 28);
        check_eq("arst_bits",       bit_bad, 0);
        check_eq("arst_err",        err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_usb_tx_arbiter
`default_nettype wire
